// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter
//   Shares the 386SX bus between the CPU and two secondary masters (DMA on
//   req[0], debug on req[1]) through the HOLD/HLDA handshake. Requests are
//   arbitrated round-robin, HOLD is raised, and the winner is granted only
//   after HOLDA is seen. After every tenure the CPU is guaranteed CPU_GAP
//   idle cycles before HOLD can be raised again.
//
// Ports
//   clk      in   single clock (2x CPU clock), all logic on posedge
//   reset    in   synchronous, active-high
//   req[1:0] in   level requests, bit 0 DMA, bit 1 debug
//   holda    in   HOLDA from the CPU, already synchronised
//   hold     out  HOLD to the CPU
//   gnt[1:0] out  one-hot grant, zero when no master owns the bus
//   preempt  out  owner has held the bus longer than MAX_TENURE cycles
//   busy     out  arbiter not in IDLE
//   err[1:0] out  sticky: bit 0 HOLDA timeout, bit 1 HOLDA lost in grant
module bus_hold_arbiter #(
  parameter int CPU_GAP       = 4,
  parameter int MAX_TENURE    = 64,
  parameter int HOLDA_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       holda,
  output logic       hold,
  output logic [1:0] gnt,
  output logic       preempt,
  output logic       busy,
  output logic [1:0] err
);

  localparam int GAP_W  = (CPU_GAP > 0) ? $clog2(CPU_GAP + 1) : 1;
  localparam int WAIT_W = (HOLDA_TIMEOUT > 1) ? $clog2(HOLDA_TIMEOUT) : 1;
  localparam int TEN_W  = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;

  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(CPU_GAP);
  // Last wait count value: HOLD_REQ cycle number HOLDA_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(HOLDA_TIMEOUT - 1);
  // Tenure saturates here; reaching it arms preempt for the next cycle.
  localparam logic [TEN_W-1:0]  TEN_LAST  = TEN_W'(MAX_TENURE - 1);

  typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANT, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic              winner_reg, winner_next;
  logic              last_reg, last_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [TEN_W-1:0]  tenure_reg, tenure_next;
  logic [1:0]        err_next;
  logic              preempt_next;
  logic              hold_next;
  logic              busy_next;
  logic [1:0]        gnt_next;
  logic              pick;

  // Round-robin: on a tie the master that was not granted last wins.
  assign pick = (req == 2'b11) ? ~last_reg : req[1];

  always_comb begin
    state_next    = state_reg;
    winner_next   = winner_reg;
    last_next     = last_reg;
    gap_next      = gap_reg;
    wait_cnt_next = wait_cnt_reg;
    tenure_next   = tenure_reg;
    err_next      = err;
    preempt_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req != 2'b00 && gap_reg == '0) begin
          winner_next   = pick;
          wait_cnt_next = '0;
          state_next    = HOLD_REQ;
        end else if (gap_reg != '0) begin
          gap_next = gap_reg - 1'b1;
        end
      end
      HOLD_REQ: begin
        if (holda && req[winner_reg]) begin
          tenure_next = '0;
          last_next   = winner_reg;
          state_next  = GRANT;
        end else if (!req[winner_reg]) begin
          state_next = RELEASE;
        end else if (wait_cnt_reg >= WAIT_LAST) begin
          err_next[0] = 1'b1;
          state_next  = RELEASE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      GRANT: begin
        if (!req[winner_reg]) begin
          state_next = RELEASE;
        end else if (!holda) begin
          err_next[1] = 1'b1;
          state_next  = RELEASE;
        end else if (tenure_reg == TEN_LAST) begin
          // Preempt only signals; the owner keeps the bus until it drops req.
          preempt_next = 1'b1;
        end else begin
          tenure_next = tenure_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (!holda) begin
          gap_next   = GAP_LOAD;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so that they leave the flops
    // in the same cycle the state does.
    hold_next = (state_next == HOLD_REQ) || (state_next == GRANT);
    busy_next = (state_next != IDLE);
    gnt_next  = 2'b00;
    if (state_next == GRANT) begin
      gnt_next = winner_next ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      winner_reg   <= 1'b0;
      last_reg     <= 1'b1;   // makes req[0] win the first tie
      gap_reg      <= '0;
      wait_cnt_reg <= '0;
      tenure_reg   <= '0;
      hold         <= 1'b0;
      gnt          <= 2'b00;
      preempt      <= 1'b0;
      busy         <= 1'b0;
      err          <= 2'b00;
    end else begin
      state_reg    <= state_next;
      winner_reg   <= winner_next;
      last_reg     <= last_next;
      gap_reg      <= gap_next;
      wait_cnt_reg <= wait_cnt_next;
      tenure_reg   <= tenure_next;
      hold         <= hold_next;
      gnt          <= gnt_next;
      preempt      <= preempt_next;
      busy         <= busy_next;
      err          <= err_next;
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// tb_bus_hold_arbiter
//   Directed scenarios followed by a randomized run. Every cycle the DUT
//   outputs are compared with a behavioural model that tracks who is asking,
//   who owns the bus and how many cycles each phase has lasted.
module tb_bus_hold_arbiter;

  localparam int GAP = 4;
  localparam int TEN = 8;
  localparam int TO  = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       holda = 1'b0;
  logic       hold;
  logic [1:0] gnt;
  logic       preempt;
  logic       busy;
  logic [1:0] err;

  int compared = 0;
  int mismatched = 0;
  int cpu_mode = 0;   // 0: holda driven by hand, 1: follows hold, 2: random CPU

  // Behavioural model state.
  int         m_ask = -1;    // master waiting for HOLDA, -1 none
  int         m_own = -1;    // master owning the bus, -1 none
  bit         m_rel = 1'b0;  // waiting for the CPU to drop HOLDA
  int         m_cool = 0;    // idle cycles still owed to the CPU
  int         m_asked = 0;   // HOLD_REQ cycles so far, including current
  int         m_owned = 0;   // grant cycles so far, including current
  int         m_last = 1;    // last master actually granted
  logic [1:0] m_err = 2'b00;

  bus_hold_arbiter #(
    .CPU_GAP(GAP),
    .MAX_TENURE(TEN),
    .HOLDA_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .holda(holda),
    .hold(hold),
    .gnt(gnt),
    .preempt(preempt),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic [1:0] r, input logic h, input logic rs);
    if (rs) begin
      m_ask = -1; m_own = -1; m_rel = 1'b0; m_cool = 0;
      m_asked = 0; m_owned = 0; m_last = 1; m_err = 2'b00;
    end else if (m_ask >= 0) begin
      if (h && r[m_ask]) begin
        m_own = m_ask; m_last = m_ask; m_ask = -1; m_owned = 1;
      end else if (!r[m_ask]) begin
        m_ask = -1; m_rel = 1'b1;
      end else if (m_asked >= TO) begin
        m_err[0] = 1'b1; m_ask = -1; m_rel = 1'b1;
      end else begin
        m_asked++;
      end
    end else if (m_own >= 0) begin
      if (!r[m_own]) begin
        m_own = -1; m_rel = 1'b1;
      end else if (!h) begin
        m_err[1] = 1'b1; m_own = -1; m_rel = 1'b1;
      end else begin
        m_owned++;
      end
    end else if (m_rel) begin
      if (!h) begin
        m_rel = 1'b0; m_cool = GAP;
      end
    end else begin
      if (r != 2'b00 && m_cool == 0) begin
        if (r == 2'b11) m_ask = 1 - m_last;
        else m_ask = r[1] ? 1 : 0;
        m_asked = 1;
      end else if (m_cool > 0) begin
        m_cool--;
      end
    end
  endtask

  // One clock: sample inputs, advance model, compare all outputs after the edge.
  task automatic tick();
    logic [1:0] r;
    logic h, rs;
    logic [1:0] e_gnt;
    r = req; h = holda; rs = reset;
    @(posedge clk);
    model_step(r, h, rs);
    #1;
    e_gnt = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    check("hold", 32'(hold), 32'((m_ask >= 0) || (m_own >= 0)));
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("preempt", 32'(preempt), 32'((m_own >= 0) && (m_owned > TEN)));
    check("busy", 32'(busy), 32'((m_ask >= 0) || (m_own >= 0) || m_rel));
    check("err", 32'(err), 32'(m_err));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("gnt_needs_hold", 32'((gnt == 2'b00) || (hold && h)), 32'd1);
    if (cpu_mode == 1) begin
      holda = hold;
    end else if (cpu_mode == 2) begin
      if (hold && !holda) holda = ($urandom_range(2) == 0);
      else if (!hold && holda) holda = ($urandom_range(1) == 0) ? 1'b0 : 1'b1;
      else if (hold && holda && $urandom_range(80) == 0) holda = 1'b0;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (gnt === 2'b00 && n < budget) begin
      tick();
      n++;
    end
    check("wait_gnt_bound", 32'(gnt !== 2'b00), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; holda = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int hc;
    int n;

    // Reset state.
    cpu_mode = 0;
    do_reset();
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic handshake, holda answers three cycles after hold.
    req = 2'b01;
    tick();
    check("hs_hold", 32'(hold), 32'd1);
    tick();
    tick();
    tick();
    check("hs_nogrant_yet", 32'(gnt), 32'd0);
    holda = 1'b1;
    tick();
    check("hs_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    tick();
    check("hs_drop_gnt", 32'(gnt), 32'd0);
    check("hs_drop_hold", 32'(hold), 32'd0);
    holda = 1'b0;
    tick();
    check("hs_busy_off", 32'(busy), 32'd0);

    // Round-robin alternation on tied requests.
    do_reset();
    cpu_mode = 1;
    req = 2'b11;
    wait_gnt(20);
    check("rr_first", 32'(gnt), 32'h1);
    req = 2'b10;
    tick();
    req = 2'b11;
    tick();
    wait_gnt(30);
    check("rr_second", 32'(gnt), 32'h2);
    req = 2'b01;
    tick();
    req = 2'b11;
    tick();
    wait_gnt(30);
    check("rr_third", 32'(gnt), 32'h1);
    req = 2'b00;
    for (int i = 0; i < 12; i++) tick();

    // Tenure limit: preempt rises but the grant stays.
    do_reset();
    cpu_mode = 1;
    req = 2'b01;
    wait_gnt(20);
    for (int i = 0; i < 20; i++) tick();
    check("ten_preempt", 32'(preempt), 32'd1);
    check("ten_gnt_kept", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    check("ten_gnt_off", 32'(gnt), 32'd0);
    check("ten_preempt_off", 32'(preempt), 32'd0);
    for (int i = 0; i < 8; i++) tick();

    // HOLDA timeout: CPU never answers.
    do_reset();
    cpu_mode = 0;
    holda = 1'b0;
    req = 2'b10;
    hc = 0;
    n = 0;
    while (err === 2'b00 && n < 300) begin
      tick();
      if (hold === 1'b1) hc++;
      n++;
    end
    check("to_err", 32'(err), 32'h1);
    check("to_hold_off", 32'(hold), 32'd0);
    check("to_len", 32'(hc), 32'(TO));
    n = 0;
    while (hold !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check("to_retry_hold", 32'(hold), 32'd1);
    check("to_err_sticky", 32'(err), 32'h1);

    // HOLDA lost during grant, then reset clears everything.
    do_reset();
    cpu_mode = 1;
    req = 2'b01;
    wait_gnt(20);
    tick();
    cpu_mode = 0;
    holda = 1'b0;
    tick();
    check("lost_err", 32'(err), 32'h2);
    check("lost_gnt", 32'(gnt), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("lost_rst_err", 32'(err), 32'd0);
    check("lost_rst_out", 32'({hold, gnt, preempt, busy}), 32'd0);

    // Reset in the middle of a grant with holda still high.
    cpu_mode = 1;
    req = 2'b10;
    wait_gnt(20);
    cpu_mode = 0;
    holda = 1'b1;
    reset = 1'b1;
    tick();
    check("midrst_hold", 32'(hold), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;
    holda = 1'b0;
    req = 2'b00;
    tick();

    // Randomized traffic with a loosely behaved CPU.
    cpu_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) req[0] = ~req[0];
      if ($urandom_range(5) == 0) req[1] = ~req[1];
      reset = ($urandom_range(500) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_hold_arbiter.md
BUS_HOLD_ARBITER -- requirements
Module: bus_hold_arbiter

Interface
REQ-001 SHALL have parameter CPU_GAP, default 4: minimum idle cycles after HOLDA falls before HOLD may be reasserted.
REQ-002 SHALL have parameter MAX_TENURE, default 64: grant cycles after which preempt asserts.
REQ-003 SHALL have parameter HOLDA_TIMEOUT, default 255: HOLD_REQ cycles before the timeout error is raised.
REQ-004 SHALL have port clk, input, 1: single clock, 2x CPU clock domain; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port req, input, 2: bus requests from secondary masters (bit 0 DMA, bit 1 debug), level.
REQ-007 SHALL have port holda, input, 1: HOLDA from the 386SX, assumed already synchronised.
REQ-008 SHALL have port hold, output, 1: HOLD to the 386SX.
REQ-009 SHALL have port gnt, output, 2: one-hot grant; all zero when no master owns the bus.
REQ-010 SHALL have port preempt, output, 1: owner has exceeded MAX_TENURE and must drop req.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port err, output, 2: sticky flags; bit 0 HOLDA timeout, bit 1 HOLDA lost during grant.

Function
REQ-013 SHALL implement states IDLE, HOLD_REQ, GRANT and RELEASE; all outputs are registered.
REQ-014 IDLE: hold=0, gnt=0; gap counter decrements to 0; with any req set and gap counter 0, the arbiter SHALL latch the winner and enter HOLD_REQ.
REQ-015 Winner selection SHALL be round-robin: the last-granted master has lower priority; after reset, req[0] wins a tie.
REQ-016 HOLD_REQ: hold=1; a wait counter counts cycles.
REQ-017 HOLD_REQ, holda=1 while req[winner] is still set: gnt[winner]=1 SHALL be registered on the next edge and the state SHALL become GRANT.
REQ-018 HOLD_REQ, req[winner] drops before holda: the state SHALL go to RELEASE with no grant issued.
REQ-019 HOLD_REQ, wait counter reaches HOLDA_TIMEOUT: err[0] SHALL be set and the state SHALL go to RELEASE.
REQ-020 GRANT: hold=1, gnt one-hot, and a tenure counter SHALL start at 0 on entry.
REQ-021 GRANT: when the tenure counter reaches MAX_TENURE-1, preempt SHALL be 1 from the next cycle until the grant ends.
REQ-022 The tenure counter SHALL saturate and never wrap.
REQ-023 The grant SHALL NOT be revoked by preempt; only the owner dropping req ends it.
REQ-024 GRANT, req[owner]=0: the arbiter SHALL go to RELEASE; gnt and preempt SHALL be 0 on the next cycle.
REQ-025 GRANT, holda=0 while req[owner]=1: err[1] SHALL be set, gnt dropped and the state SHALL go to RELEASE.
REQ-026 RELEASE: hold=0, gnt=0; on holda=0 the gap counter SHALL be loaded with CPU_GAP and the state SHALL go to IDLE.
REQ-027 With CPU_GAP=0, IDLE SHALL be able to re-enter HOLD_REQ on the first IDLE cycle.
REQ-028 A request from the non-owner during GRANT SHALL be held pending and served only after RELEASE, IDLE and the gap; it SHALL NOT be handed over directly.
REQ-029 gnt SHALL never have more than one bit set.
REQ-030 gnt SHALL never be nonzero while hold=0 or while holda has not been sampled high.
REQ-031 err bits SHALL be sticky and cleared only by reset; errors SHALL NOT block further arbitration.

Reset
REQ-032 While reset=1 at a clk edge: state IDLE, hold=0, gnt=00, preempt=0, busy=0, err=00.
REQ-033 While reset=1 at a clk edge: gap, wait and tenure counters 0; round-robin pointer favours req[0].
REQ-034 Reset asserted mid-GRANT SHALL drop hold and gnt on that edge, regardless of holda.

Verification
REQ-035 req=01, holda follows hold after 3 cycles -> hold=1 one cycle after req; gnt=01 one cycle after holda=1; req=00 -> gnt=00 and hold=0 next cycle; busy=0 once holda=0.
REQ-036 req=11 from reset -> gnt=01 first; after release plus 4 idle cycles, gnt=10; repeat -> gnt=01 (alternation).
REQ-037 MAX_TENURE=8, req=01 held 20 cycles -> preempt=1 from the 9th grant cycle, gnt stays 01 until req drops, then gnt=00 and preempt=0.
REQ-038 holda tied 0, req=10, HOLDA_TIMEOUT=255 -> err=01 after 255 HOLD_REQ cycles, hold=0; a later req retries and hold=1 again.
REQ-039 During GRANT, holda forced 0 -> err=10, gnt=00 next cycle; then reset=1 for one edge -> err=00, all outputs 0.
